// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Initiator for the data-memory port. Takes one request at a time (byte,
//   word, 4-word or 8-word burst; read or write), drives the memory command
//   pins and streams beats with valid/ready handshakes. Consumer backpressure
//   on reads and missing write beats both become mem_stall.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake; req_addr/size/rd_wr
//   wdata/wdata_valid/wdata_ready   write beat stream
//   rsp_data/rsp_valid/rsp_ready    read beat stream, rsp_last on final beat
//   wr_done, err                    one-cycle status pulses
//   flush                           abort the current transaction
//   mem_*                           memory pins (addr, wdata, rdata, size,
//                                   rd_wr, enable, stall, clear, busy)
module mem_burst_master #(
  parameter logic [31:0] ADDR_BASE = 32'h8002_0000,
  parameter logic [31:0] MEM_BYTES = 32'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_rd_wr,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_last,
  output logic        wr_done,
  output logic        err,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  mem_size,
  output logic        mem_rd_wr,
  output logic        mem_enable,
  output logic        mem_stall,
  output logic        mem_clear,
  input  logic        mem_busy
);

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_4WORD = 2'b10;
  localparam logic [1:0] SZ_8WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, CMD, RBEAT, WBEAT} state_t;

  state_t     state;
  logic [2:0] count;

  // Sequencing runs off the beat counter; busy is only observed by memory.
  logic unused_busy;
  assign unused_busy = mem_busy;

  function automatic logic [2:0] beats_m1(input logic [1:0] sz);
    case (sz)
      SZ_4WORD: return 3'd3;
      SZ_8WORD: return 3'd7;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [5:0] req_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE:  return 6'd1;
      SZ_WORD:  return 6'd4;
      SZ_4WORD: return 6'd16;
      default:  return 6'd32;
    endcase
  endfunction

  // Whole burst extent must fit inside the memory window.
  logic [31:0] req_off;
  logic [32:0] req_end;
  logic        req_bad;
  always_comb begin
    req_off = req_addr - ADDR_BASE;
    req_end = {1'b0, req_off} + {27'd0, req_bytes(req_size)};
    req_bad = ((req_size != SZ_BYTE) && (req_addr[1:0] != 2'b00)) ||
              (req_addr < ADDR_BASE) ||
              (req_end > {1'b0, MEM_BYTES});
  end

  logic busy_st;
  logic accept;
  assign busy_st     = (state != IDLE);
  assign req_ready   = rst_n & (state == IDLE) & ~flush;
  assign accept      = req_ready & req_valid;
  assign mem_enable  = busy_st;
  assign mem_clear   = busy_st & flush;
  assign mem_wdata   = wdata;
  assign rsp_valid   = rst_n & (state == RBEAT) & ~flush;
  assign rsp_last    = (state == RBEAT) && (count == 3'd0);
  assign rsp_data    = (mem_size == SZ_BYTE) ? {24'd0, mem_rdata[7:0]} : mem_rdata;
  assign wdata_ready = rst_n & ~flush & wdata_valid &
                       (((state == CMD) & ~mem_rd_wr) | (state == WBEAT));

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      CMD:   mem_stall = ~mem_rd_wr & ~wdata_valid;
      // Last read beat keeps stall high so data_out holds and no new
      // command is sampled before enable drops.
      RBEAT: mem_stall = (count == 3'd0) ? 1'b1 : ~rsp_ready;
      WBEAT: mem_stall = ~wdata_valid;
      default: mem_stall = 1'b0;
    endcase
    if (flush && busy_st) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 3'd0;
      mem_addr  <= 32'd0;
      mem_size  <= SZ_WORD;
      mem_rd_wr <= 1'b1;
      wr_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (req_bad) err <= 1'b1;
          else begin
            mem_addr  <= req_addr;
            mem_size  <= req_size;
            mem_rd_wr <= req_rd_wr;
            state     <= CMD;
          end
        end
        CMD: begin
          if (flush) state <= IDLE;
          else if (mem_rd_wr) begin
            state <= RBEAT;
            count <= beats_m1(mem_size);
          end else if (wdata_valid) begin
            if (beats_m1(mem_size) == 3'd0) begin
              wr_done <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= WBEAT;
              count <= beats_m1(mem_size);
            end
          end
        end
        RBEAT: begin
          if (flush) state <= IDLE;
          else if (rsp_ready) begin
            if (count == 3'd0) state <= IDLE;
            else count <= count - 3'd1;
          end
        end
        WBEAT: begin
          if (flush) state <= IDLE;
          else if (wdata_valid) begin
            if (count == 3'd1) begin
              wr_done <= 1'b1;
              state   <= IDLE;
            end
            count <= count - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural burst memory.
module tb_mem_burst_master;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam logic [31:0] BYTES = 32'd512;
  localparam int          WORDS = 128;
  localparam logic [1:0]  SB = 2'b00, SW = 2'b01, S4 = 2'b10, S8 = 2'b11;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_rd_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic        wr_done, err, flush;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_rd_wr, mem_enable, mem_stall, mem_clear, mem_busy;

  int n_chk = 0;
  int n_fail = 0;

  mem_burst_master #(.ADDR_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_rd_wr(req_rd_wr),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_last(rsp_last), .wr_done(wr_done), .err(err), .flush(flush),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_size(mem_size), .mem_rd_wr(mem_rd_wr), .mem_enable(mem_enable),
    .mem_stall(mem_stall), .mem_clear(mem_clear), .mem_busy(mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {16'hC0DE, b, b ^ 8'h5A};
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return int'(o[6:0]);
  endfunction

  function automatic int nbeats(input logic [1:0] sz);
    return (sz == S8) ? 8 : (sz == S4) ? 4 : 1;
  endfunction

  // Behavioural memory: samples a command with enable & ~stall & ~clear,
  // streams a read burst into data_out, or absorbs write beats.
  // Byte reads return junk in the upper 24 bits.
  logic [31:0] mem [0:WORDS-1];
  logic        fill, m_act, m_rd;
  int          m_ptr, m_left, wr_cnt, cmd_cnt;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
      m_act <= 1'b0; m_rd <= 1'b1; m_ptr <= 0; m_left <= 0;
      wr_cnt <= 0; cmd_cnt <= 0; mem_rdata <= 32'd0;
    end else if (!mem_enable || mem_clear) begin
      m_act <= 1'b0;
    end else if (!mem_stall && !mem_busy) begin
      if (!m_act) begin
        cmd_cnt <= cmd_cnt + 1;
        m_rd    <= mem_rd_wr;
        m_ptr   <= widx(mem_addr) + 1;
        m_left  <= nbeats(mem_size) - 1;
        if (mem_rd_wr) begin
          m_act <= 1'b1;
          mem_rdata <= (mem_size == SB) ?
            {24'hFFFFFF, mem[widx(mem_addr)][8*mem_addr[1:0] +: 8]} : mem[widx(mem_addr)];
        end else begin
          wr_cnt <= wr_cnt + 1;
          m_act  <= (nbeats(mem_size) > 1);
          if (mem_size == SB) mem[widx(mem_addr)][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
          else mem[widx(mem_addr)] <= mem_wdata;
        end
      end else if (m_rd) begin
        if (m_left != 0) begin
          mem_rdata <= mem[m_ptr];
          m_ptr <= m_ptr + 1; m_left <= m_left - 1;
        end
      end else begin
        mem[m_ptr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
        m_ptr <= m_ptr + 1; m_left <= m_left - 1;
        if (m_left == 1) m_act <= 1'b0;
      end
    end
  end

  // Bench's own record of what memory should hold.
  logic [31:0] shadow [0:WORDS-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle, then returns at the CMD cycle.
  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic rd);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_rd_wr = rd;
    #1 chk("req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("cmd_enable", {31'd0, mem_enable}, 32'd1);
    chk("cmd_addr", mem_addr, a);
    chk("cmd_size", {30'd0, mem_size}, {30'd0, sz});
    chk("cmd_rd_wr", {31'd0, mem_rd_wr}, {31'd0, rd});
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [1:0] sz, input int n,
                          input int hold_beat, input int hold_cyc);
    logic [31:0] e;
    rsp_ready = 1'b1;
    issue(a, sz, 1'b1);
    chk("cmd_rd_stall", {31'd0, mem_stall}, 32'd0);
    chk("cmd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (sz == SB) e = {24'd0, shadow[widx(a)][8*a[1:0] +: 8]};
      else          e = shadow[widx(a) + i];
      for (int h = 0; h < ((i == hold_beat) ? hold_cyc : 0); h++) begin
        @(negedge clk); rsp_ready = 1'b0;
        #1;
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_data", rsp_data, e);
        chk("hold_stall", {31'd0, mem_stall}, 32'd1);
      end
      @(negedge clk); rsp_ready = 1'b1;
      #1;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data", rsp_data, e);
      chk("rsp_last", {31'd0, rsp_last}, {31'd0, i == n - 1});
      chk("beat_stall", {31'd0, mem_stall}, {31'd0, i == n - 1});
    end
    @(negedge clk);
    #1;
    chk("rd_end_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rd_end_enable", {31'd0, mem_enable}, 32'd0);
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [1:0] sz, input int n,
                          input int gap_beat, input int gap_cyc, input logic [31:0] d0);
    int w0;
    w0 = wr_cnt;
    issue(a, sz, 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < ((i == gap_beat) ? gap_cyc : 0); g++) begin
        wdata_valid = 1'b0;
        #1;
        chk("gap_ready", {31'd0, wdata_ready}, 32'd0);
        chk("gap_stall", {31'd0, mem_stall}, 32'd1);
        chk("gap_done", {31'd0, wr_done}, 32'd0);
        @(negedge clk);
      end
      wdata_valid = 1'b1; wdata = d0 + i;
      #1;
      chk("wdata_ready", {31'd0, wdata_ready}, 32'd1);
      chk("wbeat_stall", {31'd0, mem_stall}, 32'd0);
      chk("mem_wdata", mem_wdata, d0 + i);
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1;
    chk("wr_done", {31'd0, wr_done}, 32'd1);
    chk("wr_end_enable", {31'd0, mem_enable}, 32'd0);
    @(negedge clk);
    #1;
    chk("wr_done_pulse", {31'd0, wr_done}, 32'd0);
    chk("wr_count", wr_cnt - w0, n);
    for (int i = 0; i < n; i++) begin
      if (sz == SB) shadow[widx(a)][8*a[1:0] +: 8] = d0[7:0];
      else shadow[widx(a) + i] = d0 + i;
    end
  endtask

  task automatic bad_req(input logic [31:0] a, input logic [1:0] sz);
    int c0;
    c0 = cmd_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_rd_wr = 1'b1;
    #1 chk("bad_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_enable", {31'd0, mem_enable}, 32'd0);
    @(negedge clk);
    #1;
    chk("err_clear", {31'd0, err}, 32'd0);
    chk("err_enable2", {31'd0, mem_enable}, 32'd0);
    chk("err_no_cmd", cmd_cnt - c0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
    rst_n = 1'b0; fill = 1'b1; mem_busy = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_addr = 32'd0; req_size = SW; req_rd_wr = 1'b1;
    wdata = 32'd0; wdata_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    chk("rst_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_clear", {31'd0, mem_clear}, 32'd0);
    chk("rst_rd_wr", {31'd0, mem_rd_wr}, 32'd1);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_size", {30'd0, mem_size}, {30'd0, SW});

    @(negedge clk);
    rst_n = 1'b1; fill = 1'b0;
    #1 chk("idle_ready", {31'd0, req_ready}, 32'd1);
    flush = 1'b1;
    req_valid = 1'b1; req_addr = BASE; req_size = SW; req_rd_wr = 1'b1;
    #1 chk("flush_idle_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1 chk("flush_no_accept", {31'd0, mem_enable}, 32'd0);

    rd_burst(32'h8002_0040, S8, 8, -1, 0);
    rd_burst(32'h8002_0080, S4, 4, 1, 3);

    wr_burst(32'h8002_0003, SB, 1, -1, 0, 32'h0000_00A5);
    rd_burst(32'h8002_0003, SB, 1, -1, 0);
    rd_burst(32'h8002_0000, SW, 1, -1, 0);
    chk("byte_wr_word", shadow[0], 32'hA5DE_005A);
    rd_burst(32'h8002_0004, SB, 1, -1, 0);

    wr_burst(32'h8002_0100, S8, 8, 4, 2, 32'h1234_5600);
    rd_burst(32'h8002_0100, S8, 8, -1, 0);

    // Flush on the third beat of an 8-word read.
    rsp_ready = 1'b1;
    issue(32'h8002_0040, S8, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("pre_flush_data", rsp_data, shadow[16 + i]);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_clear", {31'd0, mem_clear}, 32'd1);
    chk("flush_enable", {31'd0, mem_enable}, 32'd1);
    chk("flush_stall", {31'd0, mem_stall}, 32'd0);
    chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("post_flush_clear", {31'd0, mem_clear}, 32'd0);
    chk("post_flush_enable", {31'd0, mem_enable}, 32'd0);
    chk("post_flush_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_flush_ready", {31'd0, req_ready}, 32'd1);
    rd_burst(32'h8002_0044, SW, 1, -1, 0);

    bad_req(32'h8002_0002, SW);
    bad_req(BASE + BYTES, SW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
